branch_resolver: RTL and testbench

Sequential consumer of the comparison unit's flags: accepts a conditional-branch request, waits for the matching `sign_flag`/`zero_flag` result from the comparison stage, and resolves it. It then issues a one-cycle redirect (target or fall-through PC), followed by a pipeline-flush window when the branch is taken. It sits between the decode stage and PC logic of the 20-bit datapath, on the receiving end of the LT/EQ comparators.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_resolver_cond_eval.sv | 28 ++
 rtl/branch_resolver.sv | 142 ++++++++++++++
 tb/tb_branch_resolver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: condition codes, resolver state type, default PC width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package branch_pkg;

  localparam int DEFAULT_ADDR_W = 20;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_LT     = 3'b001;
  localparam logic [2:0] COND_GE     = 3'b010;
  localparam logic [2:0] COND_EQ     = 3'b011;
  localparam logic [2:0] COND_NE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_GT     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FLAG = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_FLUSH     = 2'd3
  } state_t;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Condition-code evaluator: maps (cond, sign, zero) to a taken decision.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       sign_flag,
  input  logic       zero_flag,
  output logic       taken
);

  // Decode the condition against the comparator flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_LT:     taken = sign_flag;
      COND_GE:     taken = ~sign_flag;
      COND_EQ:     taken = zero_flag;
      COND_NE:     taken = ~zero_flag;
      COND_LE:     taken = sign_flag | zero_flag;
      COND_GT:     taken = ~sign_flag & ~zero_flag;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts a conditional branch, waits for comparator flags, emits redirect + flush.
// Latency: redirect one cycle after the accept (ALWAYS/NEVER) or after the first valid flag.
// Backpressure: br_ready low from accept until the redirect (and flush window, if taken) completes.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_valid,
  input  logic              sign_flag,
  input  logic              zero_flag,
  output logic              redirect_valid,
  output logic              redirect_taken,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_count
);

  // Counter only needs to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] fall_q;
  logic [FC_W-1:0]   flush_cnt;

  logic              capture;
  logic              load_redirect;
  logic [2:0]        eval_cond;
  logic              eval_taken;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] redir_fall;

  // In IDLE the evaluator looks at the incoming request so ALWAYS/NEVER resolve on accept.
  cond_eval u_cond_eval (
    .cond      (eval_cond),
    .sign_flag (sign_flag),
    .zero_flag (zero_flag),
    .taken     (eval_taken)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and load strobes; operand source follows the state
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    load_redirect = 1'b0;
    eval_cond     = cond_q;
    redir_tgt     = target_q;
    redir_fall    = fall_q;
    case (state)
      ST_IDLE: begin
        eval_cond  = br_cond;
        redir_tgt  = br_target;
        redir_fall = br_pc + ADDR_W'(1);
        if (br_valid) begin
          capture = 1'b1;
          if (br_cond == COND_ALWAYS || br_cond == COND_NEVER) begin
            load_redirect = 1'b1;
            state_nxt     = ST_REDIRECT;
          end else begin
            state_nxt = ST_WAIT_FLAG;
          end
        end
      end
      ST_WAIT_FLAG: begin
        if (flag_valid) begin
          load_redirect = 1'b1;
          state_nxt     = ST_REDIRECT;
        end
      end
      ST_REDIRECT: state_nxt = redirect_taken ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:    if (flush_cnt == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request and latch the resolved redirect (held until the next one)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q         <= COND_ALWAYS;
      target_q       <= '0;
      fall_q         <= '0;
      redirect_taken <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (capture) begin
        cond_q   <= br_cond;
        target_q <= br_target;
        fall_q   <= redir_fall;
      end
      if (load_redirect) begin
        redirect_taken <= eval_taken;
        redirect_pc    <= eval_taken ? redir_tgt : redir_fall;
      end
    end
  end

  // Registered status outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_ready       <= 1'b1;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
    end else begin
      br_ready       <= (state_nxt == ST_IDLE);
      redirect_valid <= (state_nxt == ST_REDIRECT);
      flush          <= (state_nxt == ST_FLUSH);
    end
  end

  // Flush window down-counter and saturating taken-branch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt   <= '0;
      taken_count <= '0;
    end else begin
      if (state == ST_REDIRECT)
        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (state == ST_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FC_W'(1);
      if (state == ST_REDIRECT && redirect_taken && taken_count != '1)
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: table vectors, corner sequences, random traffic vs a schedule-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolver;
  import branch_pkg::*;

  localparam int AW  = 20;
  localparam int FC  = 2;
  localparam int BIG = 1000000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_pc;
  logic [AW-1:0] br_target;
  logic          flag_valid;
  logic          sign_flag;
  logic          zero_flag;

  logic          br_ready;
  logic          redirect_valid;
  logic          redirect_taken;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic [15:0]   taken_count;

  logic          s_br_ready;
  logic          s_redirect_valid;
  logic          s_redirect_taken;
  logic [AW-1:0] s_redirect_pc;
  logic          s_flush;
  logic [3:0]    s_taken_count;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_target(br_target), .flag_valid(flag_valid), .sign_flag(sign_flag),
    .zero_flag(zero_flag), .redirect_valid(redirect_valid), .redirect_taken(redirect_taken),
    .redirect_pc(redirect_pc), .flush(flush), .taken_count(taken_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  branch_resolver #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(s_br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_target(br_target), .flag_valid(flag_valid), .sign_flag(sign_flag),
    .zero_flag(zero_flag), .redirect_valid(s_redirect_valid), .redirect_taken(s_redirect_taken),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .taken_count(s_taken_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Schedule-based reference: cycle numbers of future events, not a state machine.
  int            cyc;
  int            free_at;
  int            redir_at;
  int            fl_lo, fl_hi;
  int            m_cnt;
  bit            waiting;
  logic [2:0]    p_cond;
  logic [AW-1:0] p_tgt, p_fall;
  logic [AW-1:0] s_pc, m_pc;
  bit            s_taken, m_taken;

  typedef struct {
    logic [2:0]    cond;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    int            dly;
    bit            s;
    bit            z;
    bit            tk;
    logic [AW-1:0] rpc;
  } vec_t;

  vec_t vt[9];

  function automatic bit ref_taken(input logic [2:0] c, input bit s, input bit z);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return s;
      3'd2:    return !s;
      3'd3:    return z;
      3'd4:    return !z;
      3'd5:    return s || z;
      3'd6:    return !s && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; free_at = 0; redir_at = -1; fl_lo = -1; fl_hi = -2;
    m_cnt = 0; waiting = 0; m_pc = '0; m_taken = 0;
  endtask

  task automatic schedule(input int r, input bit tk);
    redir_at = r;
    s_taken  = tk;
    s_pc     = tk ? p_tgt : p_fall;
    if (tk) begin
      fl_lo = r + 1; fl_hi = r + FC; free_at = r + FC + 1;
    end else begin
      free_at = r + 1;
    end
  endtask

  task automatic idle_inputs();
    br_valid   = 1'b0;
    flag_valid = 1'b0;
    sign_flag  = 1'($urandom);
    zero_flag  = 1'($urandom);
    br_cond    = 3'($urandom);
    br_pc      = AW'($urandom);
    br_target  = AW'($urandom);
  endtask

  // Compare this cycle's outputs with the model, apply inputs to the model, advance one clock.
  task automatic tick();
    int c16, c4;
    if (cyc == redir_at) begin
      m_pc    = s_pc;
      m_taken = s_taken;
    end
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk("br_ready",       br_ready,       (cyc >= free_at));
    chk("redirect_valid", redirect_valid, (cyc == redir_at));
    chk("redirect_taken", redirect_taken, m_taken);
    chk("redirect_pc",    redirect_pc,    m_pc);
    chk("flush",          flush,          (cyc >= fl_lo && cyc <= fl_hi));
    chk("taken_count",    taken_count,    c16);
    chk("taken_count_w4", s_taken_count,  c4);
    if (waiting && flag_valid) begin
      waiting = 0;
      schedule(cyc + 1, ref_taken(p_cond, sign_flag, zero_flag));
    end else if (cyc >= free_at && br_valid) begin
      p_cond  = br_cond;
      p_tgt   = br_target;
      p_fall  = br_pc + AW'(1);
      free_at = BIG;
      if (br_cond == 3'd0 || br_cond == 3'd7) schedule(cyc + 1, br_cond == 3'd0);
      else waiting = 1;
    end
    if (cyc == redir_at && m_taken) m_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset mid-cycle; outputs must drop to reset values before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_br_ready",       br_ready,       1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_taken", redirect_taken, 0);
    chk("rst_redirect_pc",    redirect_pc,    0);
    chk("rst_flush",          flush,          0);
    chk("rst_taken_count",    taken_count,    0);
    chk("rst_taken_count_w4", s_taken_count,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_free();
    for (int i = 0; i < 20 && cyc < free_at; i++) tick();
    if (cyc < free_at) chk("wait_free_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int fl_seen;
    idle_inputs();
    wait_free();
    br_valid  = 1'b1;
    br_cond   = v.cond;
    br_pc     = v.pc;
    br_target = v.tgt;
    tick();
    idle_inputs();
    if (v.cond != COND_ALWAYS && v.cond != COND_NEVER) begin
      for (int i = 1; i < v.dly; i++) tick();
      flag_valid = 1'b1;
      sign_flag  = v.s;
      zero_flag  = v.z;
      tick();
      idle_inputs();
    end
    chk("vec_redirect_valid", redirect_valid, 1);
    chk("vec_redirect_taken", redirect_taken, v.tk);
    chk("vec_redirect_pc",    redirect_pc,    v.rpc);
    fl_seen = 0;
    for (int i = 0; i < FC + 2; i++) begin
      tick();
      fl_seen += int'(flush);
    end
    chk("vec_flush_cycles", fl_seen, v.tk ? FC : 0);
  endtask

  initial begin
    vt[0] = '{COND_LT,     20'h00010, 20'h00400, 3, 1, 0, 1, 20'h00400};
    vt[1] = '{COND_GE,     20'h00020, 20'h00999, 1, 1, 0, 0, 20'h00021};
    vt[2] = '{COND_EQ,     20'hFFFFF, 20'h00500, 2, 0, 0, 0, 20'h00000};
    vt[3] = '{COND_ALWAYS, 20'h00700, 20'h12345, 0, 0, 0, 1, 20'h12345};
    vt[4] = '{COND_NEVER,  20'h00800, 20'h00001, 0, 1, 1, 0, 20'h00801};
    vt[5] = '{COND_LE,     20'h00030, 20'h00040, 1, 0, 1, 1, 20'h00040};
    vt[6] = '{COND_GT,     20'h00050, 20'h00060, 4, 0, 0, 1, 20'h00060};
    vt[7] = '{COND_NE,     20'h00070, 20'h00080, 2, 1, 0, 1, 20'h00080};
    vt[8] = '{COND_GT,     20'h00090, 20'h000A0, 1, 0, 1, 0, 20'h00091};

    idle_inputs();
    model_reset();
    do_reset();

    foreach (vt[i]) run_vec(vt[i]);

    // Spurious flags in IDLE and in the accept cycle; br_valid held while waiting.
    do_reset();
    idle_inputs();
    flag_valid = 1'b1; sign_flag = 1'b1;
    tick();
    tick();
    br_valid = 1'b1; br_cond = COND_LT; br_pc = 20'h00100; br_target = 20'h00200;
    flag_valid = 1'b1; sign_flag = 1'b1; zero_flag = 1'b0;
    tick();
    flag_valid = 1'b0;
    tick();
    chk("spur_ready_in_wait", br_ready, 0);
    tick();
    flag_valid = 1'b1; sign_flag = 1'b0; zero_flag = 1'b0;
    tick();
    idle_inputs();
    chk("spur_redirect_valid", redirect_valid, 1);
    chk("spur_redirect_taken", redirect_taken, 0);
    chk("spur_redirect_pc",    redirect_pc,    20'h00101);
    for (int i = 0; i < 3; i++) tick();

    // Reset while waiting for flags.
    br_valid = 1'b1; br_cond = COND_EQ; br_pc = 20'h00300; br_target = 20'h00400;
    tick();
    idle_inputs();
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Reset in the flush window.
    br_valid = 1'b1; br_cond = COND_ALWAYS; br_target = 20'h0ABCD;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_flush", flush, 1);
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back ALWAYS branches with br_valid held high, including through flush.
    do_reset();
    br_valid = 1'b1; br_cond = COND_ALWAYS; br_pc = 20'h00000; br_target = 20'h00ABC;
    for (int i = 0; i < 17 * (FC + 2); i++) tick();
    idle_inputs();
    for (int i = 0; i < FC + 2; i++) tick();
    chk("sat_count_w4", s_taken_count, 4'hF);
    chk("sat_count_w16", taken_count, 17);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      br_valid   = 1'($urandom_range(0, 1));
      br_cond    = 3'($urandom);
      br_pc      = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : AW'($urandom);
      br_target  = AW'($urandom);
      flag_valid = ($urandom_range(0, 2) == 0);
      sign_flag  = 1'($urandom);
      zero_flag  = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
